// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and single-outstanding I-cache fetcher feeding ID through a DEPTH-entry FIFO.
// Optional same-cycle response bypass on an empty FIFO is enabled by defining FQ_BYPASS_EN.
`default_nettype none

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Alt_PC_IN,
  input  logic        Request_Alt_PC_IN,
  input  logic        WANT_FREEZE_IN,
  input  logic        stall_IC,
  output logic        IC_Req_OUT,
  output logic [31:0] IC_Addr_OUT,
  input  logic        IC_Ack_IN,
  input  logic        IC_Valid_IN,
  input  logic [31:0] IC_Data_IN,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr_PC_OUT,
  output logic [31:0] Instr_PC_Plus4_OUT,
  output logic        Instr_Valid_OUT
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_WAIT  = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [31:0]   r_pc, r_addr, r_pend_pc;
  logic          r_drop, r_pend_valid;
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;

  logic        w_req, w_ack, w_resp, w_push, w_byp, w_valid, w_pop;
  logic        w_empty, w_flush, w_fifo_push, w_fifo_pop;
  logic [31:0] w_head_instr, w_head_pc;

  assign w_empty = (r_count == '0);
  assign w_ack   = IC_Ack_IN & w_req;
  assign w_resp  = (r_state == S_WAIT) & IC_Valid_IN;
  assign w_flush = Request_Alt_PC_IN & !w_empty;
  // A redirect over a non-empty FIFO discards a response arriving in the same cycle.
  assign w_push  = w_resp & !r_drop & !w_flush;

`ifdef FQ_BYPASS_EN
  assign w_byp = w_empty & w_push;
`else
  assign w_byp = 1'b0;
`endif

  assign w_valid     = !w_empty | w_byp;
  assign w_pop       = w_valid & !stall_IC & !WANT_FREEZE_IN;
  assign w_fifo_pop  = w_pop & !w_empty;
  assign w_fifo_push = w_push & !(w_byp & w_pop);

  assign w_head_instr = w_byp ? IC_Data_IN : r_instr_mem[r_rd_ptr];
  assign w_head_pc    = w_byp ? r_addr     : r_pc_mem[r_rd_ptr];

  assign Instr_Valid_OUT    = w_valid;
  assign Instr1_OUT         = w_valid ? w_head_instr : 32'h0;
  assign Instr_PC_OUT       = w_valid ? w_head_pc : 32'h0;
  assign Instr_PC_Plus4_OUT = w_valid ? (w_head_pc + 32'd4) : 32'h0;
  assign IC_Req_OUT         = w_req;
  assign IC_Addr_OUT        = w_req ? r_pc : 32'h0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ack)       w_state_nxt = S_WAIT;
      S_WAIT:  if (IC_Valid_IN) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Only one request outstanding, so requesting below DEPTH always leaves room for its word.
  always_comb begin
    w_req = RESET & (r_state == S_IDLE) & (r_count < DEPTH_C);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc         <= RESET_PC;
      r_addr       <= 32'h0;
      r_pend_pc    <= 32'h0;
      r_pend_valid <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      if (w_ack)  r_addr <= r_pc;
      if (w_resp) r_drop <= 1'b0;
      if (w_flush) begin
        r_pc         <= Alt_PC_IN;
        r_pend_valid <= 1'b0;
        if (((r_state == S_WAIT) && !IC_Valid_IN) || w_ack) r_drop <= 1'b1;
      end else if (Request_Alt_PC_IN) begin
        // Empty FIFO: the next word to arrive is the delay slot; redirect once it is fetched.
        if (w_ack || w_push) begin
          r_pc         <= Alt_PC_IN;
          r_pend_valid <= 1'b0;
        end else begin
          r_pend_valid <= 1'b1;
          r_pend_pc    <= Alt_PC_IN;
        end
      end else if (w_ack) begin
        r_pc         <= r_pend_valid ? r_pend_pc : (r_pc + 32'd4);
        r_pend_valid <= 1'b0;
      end else if (w_push && r_pend_valid) begin
        r_pc         <= r_pend_pc;
        r_pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= r_rd_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count  <= '0;
      end else begin
        r_count  <= (AW+1)'(1);
      end
    end else begin
      if (w_fifo_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fifo_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_fifo_push && !w_fifo_pop)      r_count <= r_count + 1'b1;
      else if (w_fifo_pop && !w_fifo_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fifo_push) begin
      r_instr_mem[r_wr_ptr] <= IC_Data_IN;
      r_pc_mem[r_wr_ptr]    <= r_addr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a queue-based reference model.
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        CLK, RESET;
  logic [31:0] Alt_PC_IN;
  logic        Request_Alt_PC_IN, WANT_FREEZE_IN, stall_IC;
  logic        IC_Req_OUT, IC_Ack_IN, IC_Valid_IN, Instr_Valid_OUT;
  logic [31:0] IC_Addr_OUT, IC_Data_IN, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hBFC00000)) dut (
    .CLK(CLK), .RESET(RESET),
    .Alt_PC_IN(Alt_PC_IN), .Request_Alt_PC_IN(Request_Alt_PC_IN),
    .WANT_FREEZE_IN(WANT_FREEZE_IN), .stall_IC(stall_IC),
    .IC_Req_OUT(IC_Req_OUT), .IC_Addr_OUT(IC_Addr_OUT),
    .IC_Ack_IN(IC_Ack_IN), .IC_Valid_IN(IC_Valid_IN), .IC_Data_IN(IC_Data_IN),
    .Instr1_OUT(Instr1_OUT), .Instr_PC_OUT(Instr_PC_OUT),
    .Instr_PC_Plus4_OUT(Instr_PC_Plus4_OUT), .Instr_Valid_OUT(Instr_Valid_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc, m_inflight, m_ppc;
  bit          m_busy, m_drop, m_pv;
  int          n_checks, n_errors;
  logic [31:0] held_pc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h20010005;
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = 32'hBFC00000; m_inflight = 0; m_ppc = 0;
    m_busy = 0; m_drop = 0; m_pv = 0;
  endtask

  // One cycle: drive inputs just after a falling edge, compare against the model, advance the model.
  task automatic step(input bit a, input bit vld, input bit redir, input logic [31:0] alt,
                      input bit frz, input bit stl);
    bit exp_req, byp, exp_valid, pop, ack, resp, push_ok;
    logic [31:0] exp_instr, exp_pc;
    ent_t h;
    IC_Ack_IN = a; IC_Valid_IN = vld; Request_Alt_PC_IN = redir; Alt_PC_IN = alt;
    WANT_FREEZE_IN = frz; stall_IC = stl;
    IC_Data_IN = (vld && m_busy) ? mem(m_inflight) : $urandom;
    #1;
    exp_req = !m_busy && (m_q.size() < DEPTH);
`ifdef FQ_BYPASS_EN
    byp = (m_q.size() == 0) && m_busy && vld && !m_drop;
`else
    byp = 1'b0;
`endif
    exp_valid = (m_q.size() != 0) || byp;
    exp_instr = (m_q.size() != 0) ? m_q[0].instr : (byp ? mem(m_inflight) : 32'h0);
    exp_pc    = (m_q.size() != 0) ? m_q[0].pc    : (byp ? m_inflight : 32'h0);
    chk("ic_req", {31'h0, IC_Req_OUT}, {31'h0, exp_req});
    if (exp_req) chk("ic_addr", IC_Addr_OUT, m_pc);
    chk("valid", {31'h0, Instr_Valid_OUT}, {31'h0, exp_valid});
    chk("instr", Instr1_OUT, exp_instr);
    chk("pc", Instr_PC_OUT, exp_pc);
    chk("pc4", Instr_PC_Plus4_OUT, exp_valid ? exp_pc + 32'd4 : 32'h0);

    pop  = exp_valid && !stl && !frz;
    ack  = exp_req && a;
    resp = m_busy && vld;
    push_ok = !(byp && pop);
    if (redir && m_q.size() != 0) begin
      h = m_q[0];
      m_q.delete();
      if (!pop) m_q.push_back(h);
      if (resp) begin m_busy = 0; m_drop = 0; end
      else if (m_busy) m_drop = 1;
      if (ack) begin m_inflight = m_pc; m_busy = 1; m_drop = 1; end
      m_pc = alt; m_pv = 0;
    end else if (redir) begin
      if (ack) begin
        m_inflight = m_pc; m_busy = 1; m_pc = alt; m_pv = 0;
      end else if (resp && !m_drop) begin
        if (push_ok) m_q.push_back({mem(m_inflight), m_inflight});
        m_busy = 0; m_pc = alt; m_pv = 0;
      end else begin
        if (resp) begin m_busy = 0; m_drop = 0; end
        m_pv = 1; m_ppc = alt;
      end
    end else begin
      if (pop && m_q.size() != 0) void'(m_q.pop_front());
      if (ack) begin
        m_inflight = m_pc; m_busy = 1;
        m_pc = m_pv ? m_ppc : m_pc + 32'd4;
        m_pv = 0;
      end
      if (resp) begin
        if (!m_drop) begin
          if (push_ok) m_q.push_back({mem(m_inflight), m_inflight});
          if (m_pv) begin m_pc = m_ppc; m_pv = 0; end
        end
        m_busy = 0; m_drop = 0;
      end
    end
    @(negedge CLK);
  endtask

  task automatic rand_step();
    bit a, v;
    a = ($urandom_range(0, 2) != 0);
    v = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
    step(a, v, ($urandom_range(0, 7) == 0), $urandom & 32'hFFFFFFFC,
         ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    RESET = 1'b0; IC_Ack_IN = 0; IC_Valid_IN = 0; IC_Data_IN = 0;
    Request_Alt_PC_IN = 0; Alt_PC_IN = 0; WANT_FREEZE_IN = 0; stall_IC = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_req", {31'h0, IC_Req_OUT}, 32'h0);
    chk("rst_addr", IC_Addr_OUT, 32'h0);
    chk("rst_valid", {31'h0, Instr_Valid_OUT}, 32'h0);
    chk("rst_instr", Instr1_OUT, 32'h0);
    chk("rst_pc4", Instr_PC_Plus4_OUT, 32'h0);
    RESET = 1'b1;
    @(negedge CLK);

    // First fetch: request at the reset vector, word delivered the cycle after the response.
    chk("first_addr", IC_Addr_OUT, 32'hBFC00000);
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    chk("first_instr", Instr1_OUT, 32'h20010005);
    chk("first_pc", Instr_PC_OUT, 32'hBFC00000);
    chk("first_pc4", Instr_PC_Plus4_OUT, 32'hBFC00004);

    // Stalled ID: the queue fills to exactly DEPTH and requests stop.
    repeat (12) step(1, 1, 0, 0, 0, 1);
    chk("full_req", {31'h0, IC_Req_OUT}, 32'h0);
    chk("full_count", m_q.size(), DEPTH);
    repeat (DEPTH) step(0, 0, 0, 0, 0, 0);

    // Freeze holds the head while fetching continues until full.
    repeat (3) step(1, 1, 0, 0, 0, 1);
    held_pc = m_q[0].pc;
    repeat (12) step(1, 1, 0, 0, 1, 0);
    chk("freeze_pc", Instr_PC_OUT, held_pc);
    chk("freeze_req", {31'h0, IC_Req_OUT}, 32'h0);

    // Redirect with a non-empty queue keeps only the delay slot and refetches from the target.
    step(0, 0, 1, 32'h00000400, 0, 1);
    chk("redir_head", Instr_PC_OUT, held_pc);
    chk("redir_addr", IC_Addr_OUT, 32'h00000400);
    step(0, 0, 0, 0, 0, 0);

    repeat (1500) rand_step();

    // Reset in the middle of traffic, then a stray response that must be ignored.
    RESET = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, IC_Req_OUT}, 32'h0);
    chk("mid_rst_valid", {31'h0, Instr_Valid_OUT}, 32'h0);
    chk("mid_rst_instr", Instr1_OUT, 32'h0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    repeat (1500) rand_step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
